// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// Ports: byte_valid/byte_data/byte_ready (stream), im_we/im_addr/im_wd (memory write).
// slave = the loader's view, master = the stream source / memory-side observer.
interface instr_mem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wd;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wd
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wd
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time loader: takes a framed byte stream (LEN_LO, LEN_HI, 4*N payload, XOR checksum),
// packs little-endian words and writes them to instruction memory, holding the core in reset meanwhile.
// Latency: one registered write cycle after each 4th byte; done/error/core_rst_n one cycle after CHK.
// Backpressure: byte_ready is a pure state decode, one byte per cycle, no stall for memory writes.
// Ports: clk, rst (async active-low), start, bus (slave: stream in, memory write out),
//        core_rst_n, busy, done, error.
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  instr_mem_loader_if.slave  bus,
  output logic               core_rst_n,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state, state_next;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  acc;
  logic [23:0] word_buf;   // lanes 0..2; lane 3 arrives with the write itself

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] word_idx_inc;

  assign xfer         = bus.byte_valid && bus.byte_ready;
  assign len_full     = {bus.byte_data, len[7:0]};
  assign word_idx_inc = word_idx + 16'd1;

  assign bus.byte_ready = (state == ST_LEN0) || (state == ST_LEN1) ||
                          (state == ST_DATA) || (state == ST_CHECK);
  assign busy  = bus.byte_ready;
  assign done  = (state == ST_DONE);
  assign error = (state == ST_ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_next = ST_LEN0;
      end
      ST_LEN0: begin
        if (xfer) state_next = ST_LEN1;
      end
      ST_LEN1: begin
        if (xfer) begin
          if (len_full == 16'd0 || {1'b0, len_full} > MAX_W) state_next = ST_ERR;
          else                                                 state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer && byte_idx == 2'd3 && word_idx_inc == len) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (xfer) begin
          if (bus.byte_data == acc) state_next = ST_DONE;
          else                      state_next = ST_ERR;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath. core_rst_n is decoded from the next state so it moves together with
  // the state register (and is low throughout reset, rising at the first edge after).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len        <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      acc        <= '0;
      word_buf   <= '0;
      bus.im_we  <= 1'b0;
      bus.im_addr <= '0;
      bus.im_wd  <= '0;
      core_rst_n <= 1'b0;
    end else begin
      bus.im_we  <= 1'b0;
      core_rst_n <= (state_next == ST_IDLE) || (state_next == ST_DONE);
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            word_idx <= '0;
            byte_idx <= '0;
            acc      <= '0;
          end
        end
        ST_LEN0: begin
          if (xfer) len[7:0] <= bus.byte_data;
        end
        ST_LEN1: begin
          if (xfer) len[15:8] <= bus.byte_data;
        end
        ST_DATA: begin
          if (xfer) begin
            acc      <= acc ^ bus.byte_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= bus.byte_data;
              2'd1: word_buf[15:8]  <= bus.byte_data;
              2'd2: word_buf[23:16] <= bus.byte_data;
              default: begin
                bus.im_we   <= 1'b1;
                bus.im_wd   <= {bus.byte_data, word_buf};
                bus.im_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                word_idx    <= word_idx_inc;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time program loader: the write side of the instruction memory that the single-cycle core only reads. It accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake, assembles little-endian 32-bit words and writes them into instruction memory at consecutive word addresses. While a load is in progress, it holds the core in reset through `core_rst_n`.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written; must be word-aligned.
- `MAX_WORDS`, default 1024: largest legal word count in a frame.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled request to begin a new load.
- `byte_valid` in 1: source has a byte on `byte_data`.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader can accept a byte this cycle.
- `im_we` out 1: instruction-memory write enable, one-cycle pulse per word.
- `im_addr` out 32: instruction-memory byte address of the write.
- `im_wd` out 32: instruction-memory write data.
- `core_rst_n` out 1: core reset. Low holds the core in reset.
- `busy` out 1: a load frame is in progress.
- `done` out 1: the last load completed with a good checksum.
- `error` out 1: the last load was aborted with a bad length or bad checksum.

## Operation

- Byte transfer: a byte is consumed at a rising edge where `byte_valid && byte_ready`. If `byte_valid` is high while `byte_ready` is low, the byte is not consumed and the source holds it.
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N.
  - 4·N payload bytes, least significant byte of each word first.
  - CHK: XOR of all payload bytes. The length bytes are excluded.
- States are IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERR.
- IDLE / DONE / ERR: `byte_ready`=0. `start`=1 moves to LEN0 and clears `done`, `error`, the word index, the byte index and the checksum accumulator.
- LEN0: `byte_ready`=1. On a transfer, latch `len[7:0]` and move to LEN1.
- LEN1: `byte_ready`=1. On a transfer, latch `len[15:8]`. If the full length is 0 or greater than `MAX_WORDS`, go to ERR; otherwise go to DATA.
- DATA: `byte_ready`=1.
  - Each transfer shifts the byte into word lane `byte_idx` (2-bit, 0→3) and XORs it into the accumulator.
  - On the transfer with `byte_idx`=3, register `im_we`=1, `im_wd` = assembled word and `im_addr` = `BASE_ADDR` + 4·`word_idx`. Then increment `word_idx`.
  - When `word_idx` reaches N after that write, go to CHECK.
- CHECK: `byte_ready`=1. On a transfer, go to DONE if the byte equals the accumulator, otherwise go to ERR.
- `start` is ignored in LEN0, LEN1, DATA and CHECK.
- Output decode:
  - `busy`=1 in LEN0..CHECK.
  - `done`=1 in DONE only.
  - `error`=1 in ERR only.
  - `core_rst_n`=1 in IDLE and DONE; 0 in all other states.
- Arithmetic:
  - `word_idx` is 16 bits.
  - The address is computed in 32 bits, modulo 2^32; no overflow detection.
  - Words already written before an ERR are not rolled back.

## Timing

- Reset (`rst`=0, asynchronous): state=IDLE.
  - `byte_ready`=0, `im_we`=0, `im_addr`=0, `im_wd`=0.
  - `core_rst_n`=0, `busy`=0, `done`=0, `error`=0.
  - Accumulator and counters cleared.
- After reset release: `core_rst_n` rises at the first `clk` edge, because the IDLE decode is registered.
- Reset mid-frame: aborts immediately.
  - `im_we` drops asynchronously; a partial word is never written.
  - After release the loader is in IDLE and needs a new `start`.
- `start`→LEN0: 1 cycle. `byte_ready` is high the cycle after `start` is sampled.
- Throughput: one byte per cycle with `byte_valid` held high. There is no backpressure during memory writes.
- Write timing: `im_we` is high for exactly the one cycle after the 4th-byte transfer. `im_addr` and `im_wd` are valid in that cycle and hold their values afterwards.
- Completion: CHK transfer → `done` or `error`, and the `core_rst_n` change, visible 1 cycle later.
- Frame gaps: `byte_valid` gaps of any length stall the FSM with all state held.
- `start` in DONE or ERR: begins a reload and drops `core_rst_n` next cycle.

## Test plan

- Reset: assert `rst`=0 mid-cycle → all outputs take their reset values at once. Release → `core_rst_n`=1 after one edge; `busy`/`done`/`error`=0.
- Good two-word load, `BASE_ADDR`=0:
  - Stimulus: `start`, then bytes 02 00 78 56 34 12 EF BE AD DE 2A.
  - Required: `im_we` pulses with (0x0, 0x12345678) then (0x4, 0xDEADBEEF).
  - Required: `core_rst_n`=0 from LEN0 through CHECK; `done`=1 and `core_rst_n`=1 the cycle after 0x2A.
- Bad checksum: same frame with CHK=0x2B → both words still written; `error`=1, `done`=0, `core_rst_n` stays 0.
- Illegal length:
  - LEN=00 00 → ERR after the second byte, no `im_we` pulse.
  - LEN=`MAX_WORDS`+1 → same behaviour.
  - LEN=`MAX_WORDS` → accepted.
- Stalls and stray `start`: the good frame with random `byte_valid` gaps and `start` pulsed during DATA → identical writes and final `done`; no restart.
- Reset mid-DATA: assert `rst` after 6 payload bytes → only word 0 is written, the partial word is never written, state returns to IDLE, and a following full good frame loads correctly.
